// File: rtl/bmem_port_scheduler_pkg.sv
// Shared types and constants for the bmem port scheduler and its read tracker.
// Line-aligned addresses, 4-beat bursts on a 64-bit memory port.
package bmem_port_scheduler_pkg;

  localparam int PKG_ADDR_WIDTH  = 32;
  localparam int PKG_BURST_BEATS = 4;
  localparam int BEAT_CNT_W      = $clog2(PKG_BURST_BEATS);

  typedef logic [1:0] sched_state_t;
  localparam sched_state_t IDLE     = 2'd0;
  localparam sched_state_t RD_REQ   = 2'd1;
  localparam sched_state_t WR_BURST = 2'd2;

  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  typedef struct packed {
    logic                      valid;
    logic                      stale;
    logic [PKG_ADDR_WIDTH-1:0] addr;
    logic [BEAT_CNT_W-1:0]     beat_cnt;
  } pending_rd_t;

  function automatic logic is_last_beat(input logic [BEAT_CNT_W-1:0] cnt);
    return cnt == BEAT_CNT_W'(PKG_BURST_BEATS - 1);
  endfunction

endpackage

// File: rtl/bmem_port_scheduler_rd_tracker.sv
// Tracks one outstanding read per requester (index 0 = I, 1 = D), steers returning
// beats by address tag and hides beats of squashed I-side reads.
module bmem_rd_tracker
  import bmem_port_scheduler_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PKG_ADDR_WIDTH-1:0] bmem_raddr,
  input  logic                      bmem_rvalid,
  input  logic                      i_squash,
  input  logic [1:0]                alloc,
  input  logic [PKG_ADDR_WIDTH-1:0] alloc_addr,
  output logic [1:0]                busy,
  output logic [1:0]                rvalid
);

  pending_rd_t pend_q [2];
  pending_rd_t pend_d [2];
  logic [1:0]  match;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_side
      assign match[gi]  = bmem_rvalid && pend_q[gi].valid && (bmem_raddr == pend_q[gi].addr);
      assign rvalid[gi] = match[gi] && !pend_q[gi].stale;
      assign busy[gi]   = pend_q[gi].valid;
    end
  endgenerate

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      pend_d[s] = pend_q[s];
      if (alloc[s]) begin
        pend_d[s].valid    = 1'b1;
        pend_d[s].stale    = 1'b0;
        pend_d[s].addr     = alloc_addr;
        pend_d[s].beat_cnt = '0;
      end else if (match[s]) begin
        if (is_last_beat(pend_q[s].beat_cnt)) begin
          pend_d[s] = '0;
        end else begin
          pend_d[s].beat_cnt = pend_q[s].beat_cnt + 1'b1;
        end
      end
    end
    // A squash landing on the final beat finds nothing left to mark.
    if (i_squash && pend_d[0].valid) begin
      pend_d[0].stale = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (rst) begin
        pend_q[s] <= '0;
      end else begin
        pend_q[s] <= pend_d[s];
      end
    end
  end

  a_rvalid_owned : assert property (@(posedge clk) disable iff (rst) bmem_rvalid |-> (|match));

endmodule

// File: rtl/bmem_port_scheduler.sv
// Round-robin sharing of the burst bmem port between I-cache and D-cache miss paths:
// one-cycle read requests, BURST_BEATS-beat write bursts, tag-steered read returns.
module bmem_port_scheduler
  import bmem_port_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH  = PKG_ADDR_WIDTH,
  parameter int DATA_WIDTH  = 64,
  parameter int BURST_BEATS = PKG_BURST_BEATS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_read,
  input  logic                  i_write,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  i_ready,
  output logic                  i_wdone,
  output logic                  i_rvalid,
  input  logic                  i_squash,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_ready,
  output logic                  d_wdone,
  output logic                  d_rvalid,
  output logic [ADDR_WIDTH-1:0] bmem_addr,
  output logic                  bmem_read,
  output logic                  bmem_write,
  output logic [DATA_WIDTH-1:0] bmem_wdata,
  input  logic                  bmem_ready,
  input  logic [ADDR_WIDTH-1:0] bmem_raddr,
  input  logic                  bmem_rvalid
);

  localparam int BW = $clog2(BURST_BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_BEATS - 1);

  sched_state_t  state_q, state_d;
  logic          owner_q, owner_d;
  logic          last_grant_q, last_grant_d;
  logic [BW-1:0] beat_q, beat_d;

  logic       i_rd_ok, d_rd_ok, i_req, d_req, grant;
  logic       accept, last_wr_beat;
  logic [1:0] busy, alloc, rvalid;

  // A side with a read still draining cannot issue another read, only writes.
  assign i_rd_ok = i_read && !busy[SIDE_I];
  assign d_rd_ok = d_read && !busy[SIDE_D];
  assign i_req   = i_rd_ok || i_write;
  assign d_req   = d_rd_ok || d_write;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    beat_d       = beat_q;
    grant        = SIDE_I;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          if (i_req && d_req) begin
            grant = (last_grant_q == SIDE_D) ? SIDE_I : SIDE_D;
          end else begin
            grant = d_req ? SIDE_D : SIDE_I;
          end
          owner_d      = grant;
          last_grant_d = grant;
          state_d      = ((grant == SIDE_D) ? d_rd_ok : i_rd_ok) ? RD_REQ : WR_BURST;
        end
      end
      RD_REQ: begin
        if (bmem_ready) state_d = IDLE;
      end
      WR_BURST: begin
        if (bmem_ready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= SIDE_I;
      last_grant_q <= SIDE_D;
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      beat_q       <= beat_d;
    end
  end

  assign bmem_read    = (state_q == RD_REQ);
  assign bmem_write   = (state_q == WR_BURST);
  assign bmem_addr    = (bmem_read || bmem_write) ? ((owner_q == SIDE_D) ? d_addr : i_addr) : '0;
  assign bmem_wdata   = bmem_write ? ((owner_q == SIDE_D) ? d_wdata : i_wdata) : '0;
  assign accept       = (bmem_read || bmem_write) && bmem_ready;
  assign last_wr_beat = bmem_write && bmem_ready && (beat_q == LAST_BEAT);

  assign i_ready  = accept && (owner_q == SIDE_I);
  assign d_ready  = accept && (owner_q == SIDE_D);
  assign i_wdone  = last_wr_beat && (owner_q == SIDE_I);
  assign d_wdone  = last_wr_beat && (owner_q == SIDE_D);
  assign alloc    = {bmem_read && d_ready, bmem_read && i_ready};
  assign i_rvalid = rvalid[SIDE_I];
  assign d_rvalid = rvalid[SIDE_D];

  bmem_rd_tracker u_rd_tracker (
    .clk         (clk),
    .rst         (rst),
    .bmem_raddr  (bmem_raddr),
    .bmem_rvalid (bmem_rvalid),
    .i_squash    (i_squash),
    .alloc       (alloc),
    .alloc_addr  (bmem_addr),
    .busy        (busy),
    .rvalid      (rvalid)
  );

endmodule

// File: tb/tb_bmem_port_scheduler.sv
// Directed bench for bmem_port_scheduler: read-beat and write-beat scoreboards
// checked at negedge, plus hand-sequenced grant, squash and reset scenarios.
module tb_bmem_port_scheduler;

  logic        clk, rst;
  logic [31:0] i_addr, d_addr, bmem_addr, bmem_raddr;
  logic        i_read, i_write, i_ready, i_wdone, i_rvalid, i_squash;
  logic        d_read, d_write, d_ready, d_wdone, d_rvalid;
  logic [63:0] i_wdata, d_wdata, bmem_wdata;
  logic        bmem_read, bmem_write, bmem_ready, bmem_rvalid;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [63:0] d;
  } wr_t;

  typedef struct {
    logic [31:0] raddr;
    bit          exp_i;
    bit          exp_d;
  } vec_t;

  logic [1:0] exp_q [$];
  wr_t        wq [$];
  logic [1:0] e_rv;
  wr_t        e_wr;
  vec_t       steer [8];

  bmem_port_scheduler dut (
    .clk(clk), .rst(rst),
    .i_addr(i_addr), .i_read(i_read), .i_write(i_write), .i_wdata(i_wdata),
    .i_ready(i_ready), .i_wdone(i_wdone), .i_rvalid(i_rvalid), .i_squash(i_squash),
    .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_wdone(d_wdone), .d_rvalid(d_rvalid),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
    .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready),
    .bmem_raddr(bmem_raddr), .bmem_rvalid(bmem_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] wd(input int n);
    return {32'hD0D0_0000, 32'(n)};
  endfunction

  // Memory-side monitors: every returning beat and every accepted write beat is scored.
  always @(negedge clk) begin
    if (!rst) begin
      if (bmem_rvalid) begin
        if (exp_q.size() == 0) begin
          chk("rv_unexpected", 64'd1, 64'd0);
        end else begin
          e_rv = exp_q.pop_front();
          chk("i_rvalid", 64'(i_rvalid), 64'(e_rv[1]));
          chk("d_rvalid", 64'(d_rvalid), 64'(e_rv[0]));
        end
      end else begin
        chk("rvalid_idle", 64'({i_rvalid, d_rvalid}), 64'd0);
      end
      if (bmem_write && bmem_ready) begin
        if (wq.size() == 0) begin
          chk("wr_unexpected", 64'd1, 64'd0);
        end else begin
          e_wr = wq.pop_front();
          chk("wr_addr", 64'(bmem_addr), 64'(e_wr.a));
          chk("wr_data", bmem_wdata, e_wr.d);
        end
      end
    end
  end

  task automatic beat(input logic [31:0] a, input bit ei, input bit ed);
    bmem_rvalid = 1'b1;
    bmem_raddr  = a;
    exp_q.push_back({ei, ed});
    tick();
    bmem_rvalid = 1'b0;
  endtask

  task automatic accept_read(input bit side, input logic [31:0] addr);
    int n = 0;
    while (!bmem_read && n < 20) begin
      tick();
      n++;
    end
    chk("rd_issue", 64'(bmem_read), 64'd1);
    chk("rd_addr", 64'(bmem_addr), 64'(addr));
    bmem_ready = 1'b1;
    #1;
    chk("rd_ready_own", 64'(side ? d_ready : i_ready), 64'd1);
    chk("rd_ready_other", 64'(side ? i_ready : d_ready), 64'd0);
    tick();
    bmem_ready = 1'b0;
    if (side) d_read = 1'b0;
    else      i_read = 1'b0;
  endtask

  task automatic issue_read(input bit side, input logic [31:0] addr);
    if (side) begin d_read = 1'b1; d_addr = addr; end
    else      begin i_read = 1'b1; i_addr = addr; end
    accept_read(side, addr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, 64'({i_ready, i_wdone, i_rvalid, d_ready, d_wdone, d_rvalid,
                             bmem_read, bmem_write}), 64'd0);
    chk({tag, "_addr"}, 64'(bmem_addr), 64'd0);
    chk({tag, "_wdata"}, bmem_wdata, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int wbeat;
    int pat [5];

    steer[0] = '{32'h3000, 1'b0, 1'b1};
    steer[1] = '{32'h2000, 1'b1, 1'b0};
    steer[2] = '{32'h3000, 1'b0, 1'b1};
    steer[3] = '{32'h2000, 1'b1, 1'b0};
    steer[4] = '{32'h3000, 1'b0, 1'b1};
    steer[5] = '{32'h3000, 1'b0, 1'b1};
    steer[6] = '{32'h2000, 1'b1, 1'b0};
    steer[7] = '{32'h2000, 1'b1, 1'b0};
    pat = '{1, 0, 1, 1, 1};

    rst = 1'b1; i_squash = 1'b0;
    i_addr = '0; i_read = 1'b0; i_write = 1'b0; i_wdata = '0;
    d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
    bmem_ready = 1'b0; bmem_raddr = '0; bmem_rvalid = 1'b0;

    // 1: single I read, one-cycle grant gap, four steered beats
    tick(); tick();
    chk_all_zero("reset");
    rst = 1'b0; i_read = 1'b1; i_addr = 32'h1000;
    #1 chk("t1_grant_cycle", 64'(bmem_read), 64'd0);
    tick();
    chk("t1_req", 64'(bmem_read), 64'd1);
    chk("t1_addr", 64'(bmem_addr), 64'h1000);
    chk("t1_not_ready", 64'(i_ready), 64'd0);
    tick();
    bmem_ready = 1'b1;
    #1 chk("t1_ready", 64'(i_ready), 64'd1);
    tick();
    bmem_ready = 1'b0; i_read = 1'b0;
    #1 chk("t1_ready_pulse", 64'(i_ready), 64'd0);
    chk("t1_back_idle", 64'(bmem_read), 64'd0);
    for (int b = 0; b < 4; b++) beat(32'h1000, 1'b1, 1'b0);

    // 2: simultaneous reads after reset, I wins, interleaved returns
    do_reset();
    i_read = 1'b1; i_addr = 32'h2000;
    d_read = 1'b1; d_addr = 32'h3000;
    tick();
    accept_read(1'b0, 32'h2000);
    chk("t2_gap", 64'(bmem_read), 64'd0);
    accept_read(1'b1, 32'h3000);
    for (int v = 0; v < 8; v++) beat(steer[v].raddr, steer[v].exp_i, steer[v].exp_d);

    // 3: D write burst with a stall beat; an I read raised mid-burst must wait
    d_write = 1'b1; d_addr = 32'h4000; wbeat = 0; d_wdata = wd(0);
    tick();
    chk("t3_wr_active", 64'(bmem_write), 64'd1);
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin i_read = 1'b1; i_addr = 32'h5000; end
      bmem_ready = pat[k][0];
      if (pat[k] != 0) wq.push_back({32'h4000, d_wdata});
      #1;
      chk("t3_d_ready", 64'(d_ready), 64'(pat[k]));
      chk("t3_d_wdone", 64'(d_wdone), 64'((pat[k] != 0) && (wbeat == 3)));
      chk("t3_i_blocked", 64'(i_ready | bmem_read), 64'd0);
      tick();
      if (pat[k] != 0) begin wbeat++; d_wdata = wd(wbeat); end
    end
    d_write = 1'b0; bmem_ready = 1'b0;
    #1 chk("t3_burst_end", 64'(bmem_write), 64'd0);

    // 4: squash the 0x5000 read; the held 0x6000 read waits for the drain
    accept_read(1'b0, 32'h5000);
    i_squash = 1'b1; i_read = 1'b1; i_addr = 32'h6000;
    #1 chk("t4_blocked_sq", 64'(bmem_read), 64'd0);
    tick();
    i_squash = 1'b0;
    chk("t4_blocked_0", 64'(bmem_read), 64'd0);
    for (int b = 0; b < 4; b++) begin
      beat(32'h5000, 1'b0, 1'b0);
      chk("t4_blocked_drain", 64'(bmem_read), 64'd0);
    end
    tick();
    chk("t4_regrant", 64'(bmem_read), 64'd1);
    accept_read(1'b0, 32'h6000);
    for (int b = 0; b < 4; b++) beat(32'h6000, 1'b1, 1'b0);

    // 5: both sides pending on one line, I squashed, then both tables reusable
    issue_read(1'b0, 32'h7000);
    issue_read(1'b1, 32'h7000);
    i_squash = 1'b1;
    tick();
    i_squash = 1'b0;
    for (int b = 0; b < 4; b++) beat(32'h7000, 1'b0, 1'b1);
    i_read = 1'b1; i_addr = 32'h8000;
    d_read = 1'b1; d_addr = 32'h9000;
    accept_read(1'b0, 32'h8000);
    accept_read(1'b1, 32'h9000);
    for (int b = 0; b < 4; b++) beat(32'h8000, 1'b1, 1'b0);
    for (int b = 0; b < 4; b++) beat(32'h9000, 1'b0, 1'b1);

    // 6: reset during beat 2 of an I write; next tie still goes to I
    i_write = 1'b1; i_addr = 32'hA000; wbeat = 16; i_wdata = wd(16);
    tick();
    for (int k = 0; k < 2; k++) begin
      bmem_ready = 1'b1;
      wq.push_back({32'hA000, i_wdata});
      tick();
      wbeat++; i_wdata = wd(wbeat);
    end
    bmem_ready = 1'b0; i_write = 1'b0; rst = 1'b1;
    #1 chk("t6_mid_burst", 64'(bmem_write), 64'd1);
    tick();
    rst = 1'b0;
    chk_all_zero("t6_after_rst");
    i_read = 1'b1; i_addr = 32'hB000;
    d_read = 1'b1; d_addr = 32'hC000;
    accept_read(1'b0, 32'hB000);
    accept_read(1'b1, 32'hC000);
    for (int b = 0; b < 4; b++) beat(32'hB000, 1'b1, 1'b0);
    for (int b = 0; b < 4; b++) beat(32'hC000, 1'b0, 1'b1);

    tick();
    chk("rv_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("wr_queue_empty", 64'(wq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
